// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg -- shared definitions for the instruction fetch unit.
//
// Contents:
//   XLEN        address / data path width in bits
//   INSTR_W     instruction word width in bits
//   WORD_BYTES  byte stride between consecutive instruction words
//   fetch_state_e  fetch FSM state encoding
//   is_word_aligned()  true when a byte address is a legal fetch target
// ----------------------------------------------------------------------------
package mips_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned INSTR_W = 32;

   localparam logic [XLEN-1:0] WORD_BYTES = 32'd4;

   typedef enum logic [1:0] {
      FETCH = 2'd0,  // request outstanding at fetch_pc
      VALID = 2'd1,  // instruction presented to the datapath
      DRAIN = 2'd2,  // waiting out a request made stale by a redirect
      HALT  = 2'd3   // misaligned redirect seen; frozen until reset
   } fetch_state_e;

   // Instruction fetch targets must sit on a 4-byte boundary.
   function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage : mips_pkg

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch -- single-outstanding-request instruction fetch unit.
//
// Issues one word fetch at a time, presents the returned word to the
// datapath, and advances by 4 once the datapath consumes it.  Redirects
// (taken branches / jumps) retarget fetching; a redirect that arrives while a
// request is still in flight waits for that response and throws it away.
// A misaligned redirect target is a fatal error: the unit halts with a sticky
// fault until reset.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-low reset
//   imem_req     out  fetch request to instruction memory
//   imem_addr    out  fetch byte address (word aligned, stable until ack)
//   imem_ack     in   one-cycle response strobe, imem_rdata valid with it
//   imem_rdata   in   returned instruction word
//   redirect     in   taken branch / jump from the datapath
//   redirect_pc  in   redirect target byte address
//   instr_valid  out  instr / pc hold an instruction for the datapath
//   instr_ready  in   datapath consumes instr this cycle
//   instr        out  fetched instruction word
//   pc           out  address of instr
//   pc_plus4     out  pc + 4, modulo 2^32
//   fault        out  sticky misaligned-redirect error
//   fetch_count  out  number of instructions consumed, modulo 2^32
// ----------------------------------------------------------------------------
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   output logic                imem_req,
   output logic [XLEN-1:0]     imem_addr,
   input  logic                imem_ack,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                redirect,
   input  logic [XLEN-1:0]     redirect_pc,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [INSTR_W-1:0]  instr,
   output logic [XLEN-1:0]     pc,
   output logic [XLEN-1:0]     pc_plus4,
   output logic                fault,
   output logic [XLEN-1:0]     fetch_count
);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   fetch_state_e        state_q,       state_d;
   logic [XLEN-1:0]     fetch_pc_q,    fetch_pc_d;     // address being fetched
   logic [XLEN-1:0]     target_q,      target_d;       // redirect target held across DRAIN
   logic                halt_pend_q,   halt_pend_d;    // DRAIN ends in HALT, not FETCH
   logic [INSTR_W-1:0]  instr_q,       instr_d;
   logic [XLEN-1:0]     pc_q,          pc_d;
   logic                fault_q,       fault_d;
   logic [XLEN-1:0]     fetch_count_q, fetch_count_d;

   // Redirect qualifiers shared by every state.
   logic redirect_ok;    // aligned redirect, a legal new target
   logic redirect_bad;   // misaligned redirect, fatal

   // DRAIN resolution: a redirect in the ack cycle itself still counts
   // (last redirect wins), so fold it in before choosing the exit.
   logic [XLEN-1:0] drain_target;
   logic            drain_halt;

   assign redirect_ok  = redirect &&  is_word_aligned(redirect_pc);
   assign redirect_bad = redirect && !is_word_aligned(redirect_pc);

   assign drain_target = redirect_ok ? redirect_pc : target_q;
   assign drain_halt   = halt_pend_q || redirect_bad;

   // -------------------------------------------------------------------------
   // Next-state / datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every _d signal gets its hold value first so that no path
      // through the case below leaves one unassigned and infers a latch.
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      target_d      = target_q;
      halt_pend_d   = halt_pend_q;
      instr_d       = instr_q;
      pc_d          = pc_q;
      fault_d       = fault_q;
      fetch_count_d = fetch_count_q;

      unique case (state_q)
         FETCH: begin
            if (redirect_bad) begin
               fault_d = 1'b1;
               if (imem_ack) begin
                  state_d = HALT;
               end else begin
                  // Request still in flight: wait for it before halting.
                  halt_pend_d = 1'b1;
                  state_d     = DRAIN;
               end
            end else if (redirect_ok) begin
               if (imem_ack) begin
                  // Response is for the old path; drop it and refetch.
                  fetch_pc_d = redirect_pc;
               end else begin
                  target_d    = redirect_pc;
                  halt_pend_d = 1'b0;
                  state_d     = DRAIN;
               end
            end else if (imem_ack) begin
               instr_d = imem_rdata;
               pc_d    = fetch_pc_q;
               state_d = VALID;
            end
         end

         VALID: begin
            // Redirect outranks instr_ready: the held word is discarded and
            // is not counted as consumed.
            if (redirect_bad) begin
               fault_d = 1'b1;
               state_d = HALT;
            end else if (redirect_ok) begin
               fetch_pc_d = redirect_pc;
               state_d    = FETCH;
            end else if (instr_ready) begin
               fetch_pc_d    = fetch_pc_q + WORD_BYTES;
               fetch_count_d = fetch_count_q + 32'd1;
               state_d       = FETCH;
            end
         end

         DRAIN: begin
            // fetch_pc_q is left untouched here so imem_addr keeps naming the
            // outstanding request until it is acknowledged.
            if (redirect_bad) begin
               fault_d     = 1'b1;
               halt_pend_d = 1'b1;
            end else if (redirect_ok) begin
               target_d = redirect_pc;
            end

            if (imem_ack) begin
               if (drain_halt) begin
                  state_d = HALT;
               end else begin
                  fetch_pc_d = drain_target;
                  state_d    = FETCH;
               end
            end
         end

         HALT: begin
            // Frozen until reset; all inputs are ignored.
         end

         default: begin
            state_d = HALT;
            fault_d = 1'b1;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   // NOTE: non-blocking assignments so every flop samples the pre-edge value
   // of its _d input regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= FETCH;
         fetch_pc_q    <= RESET_PC;
         target_q      <= RESET_PC;
         halt_pend_q   <= 1'b0;
         instr_q       <= '0;
         pc_q          <= '0;
         fault_q       <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         target_q      <= target_d;
         halt_pend_q   <= halt_pend_d;
         instr_q       <= instr_d;
         pc_q          <= pc_d;
         fault_q       <= fault_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // Handshake outputs decode the registered state and are gated by reset so
   // they are quiet during reset yet request RESET_PC in the very first cycle
   // after release.
   assign imem_req    = reset && ((state_q == FETCH) || (state_q == DRAIN));
   assign instr_valid = reset &&  (state_q == VALID);

   assign imem_addr   = fetch_pc_q;
   assign instr       = instr_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_q + WORD_BYTES;
   assign fault       = fault_q;
   assign fetch_count = fetch_count_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch -- directed, table-driven bench for instr_fetch.
//
// Each vector gives the inputs driven for one clock cycle together with the
// outputs expected during that same cycle (outputs reflect the state reached
// at the previous rising edge).  Inputs change on the falling edge and are
// compared 1 ns later.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

   typedef struct {
      // inputs
      logic        rst;
      logic        ack;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        rdy;
      // expected outputs
      logic        req;
      logic [31:0] addr;
      logic        val;
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        flt;
      logic [31:0] cnt;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fault;
   logic [31:0] fetch_count;

   int n_checks = 0;
   int n_pass   = 0;
   int row      = 0;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .fault       (fault),
      .fetch_count (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v(
      input logic rst, input logic ack, input logic [31:0] rdata,
      input logic redir, input logic [31:0] rpc, input logic rdy,
      input logic req, input logic [31:0] addr, input logic val,
      input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] pc4,
      input logic flt, input logic [31:0] cnt);
      vec_t r;
      r.rst = rst;   r.ack = ack;   r.rdata = rdata;
      r.redir = redir; r.rpc = rpc; r.rdy = rdy;
      r.req = req;   r.addr = addr; r.val = val;
      r.ins = ins;   r.pc = pcv;    r.pc4 = pc4;
      r.flt = flt;   r.cnt = cnt;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      else
         n_pass++;
   endtask

   // Drive one cycle of inputs and compare that cycle's outputs.
   task automatic apply(input vec_t t);
      string tag;
      @(negedge clk);
      reset       = t.rst;
      imem_ack    = t.ack;
      imem_rdata  = t.rdata;
      redirect    = t.redir;
      redirect_pc = t.rpc;
      instr_ready = t.rdy;
      #1;
      tag = $sformatf("row%0d", row);
      check({tag, " imem_req"},    {31'd0, imem_req},    {31'd0, t.req});
      check({tag, " imem_addr"},   imem_addr,            t.addr);
      check({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, t.val});
      check({tag, " instr"},       instr,                t.ins);
      check({tag, " pc"},          pc,                   t.pc);
      check({tag, " pc_plus4"},    pc_plus4,             t.pc4);
      check({tag, " fault"},       {31'd0, fault},       {31'd0, t.flt});
      check({tag, " fetch_count"}, fetch_count,          t.cnt);
      row++;
   endtask

   vec_t tbl[$];

   initial begin
      reset       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b0;
      repeat (2) @(posedge clk);

      // ---------------------------------------------------------------
      // Table: reset, three sequential fetches, 5-cycle stall in VALID.
      //         rst ack rdata          rd  rpc  rdy | req addr       val instr          pc         pc4        f  cnt
      // ---------------------------------------------------------------
      // ack during reset is ignored
      tbl.push_back(v(0, 1, 32'hDEAD_BEEF, 0, 0, 0,   0, 32'h0,      0, 32'h0,         32'h0,     32'h4,     0, 0));
      // first cycle out of reset requests RESET_PC
      tbl.push_back(v(1, 0, 32'h0,         0, 0, 0,   1, 32'h0,      0, 32'h0,         32'h0,     32'h4,     0, 0));
      tbl.push_back(v(1, 1, 32'hA000_0000, 0, 0, 0,   1, 32'h0,      0, 32'h0,         32'h0,     32'h4,     0, 0));
      tbl.push_back(v(1, 0, 32'h0,         0, 0, 1,   0, 32'h0,      1, 32'hA000_0000, 32'h0,     32'h4,     0, 0));
      tbl.push_back(v(1, 0, 32'h0,         0, 0, 0,   1, 32'h4,      0, 32'hA000_0000, 32'h0,     32'h4,     0, 1));
      tbl.push_back(v(1, 1, 32'hA000_0004, 0, 0, 0,   1, 32'h4,      0, 32'hA000_0000, 32'h0,     32'h4,     0, 1));
      tbl.push_back(v(1, 0, 32'h0,         0, 0, 1,   0, 32'h4,      1, 32'hA000_0004, 32'h4,     32'h8,     0, 1));
      tbl.push_back(v(1, 0, 32'h0,         0, 0, 0,   1, 32'h8,      0, 32'hA000_0004, 32'h4,     32'h8,     0, 2));
      tbl.push_back(v(1, 1, 32'hA000_0008, 0, 0, 0,   1, 32'h8,      0, 32'hA000_0004, 32'h4,     32'h8,     0, 2));
      // datapath stalls 5 cycles: everything holds
      for (int i = 0; i < 5; i++)
         tbl.push_back(v(1, 0, 32'h0,      0, 0, 0,   0, 32'h8,      1, 32'hA000_0008, 32'h8,     32'hC,     0, 2));
      tbl.push_back(v(1, 0, 32'h0,         0, 0, 1,   0, 32'h8,      1, 32'hA000_0008, 32'h8,     32'hC,     0, 2));
      tbl.push_back(v(1, 0, 32'h0,         0, 0, 0,   1, 32'hC,      0, 32'hA000_0008, 32'h8,     32'hC,     0, 3));

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i]);

      // ---------------------------------------------------------------
      // Redirect to 0x100 in FETCH, ack 3 cycles later: drain and refetch.
      // ---------------------------------------------------------------
      apply(v(1, 0, 32'h0,         1, 32'h100, 0,  1, 32'hC,   0, 32'hA000_0008, 32'h8, 32'hC, 0, 3));
      apply(v(1, 0, 32'h0,         0, 32'h0,   0,  1, 32'hC,   0, 32'hA000_0008, 32'h8, 32'hC, 0, 3));
      apply(v(1, 0, 32'h0,         0, 32'h0,   0,  1, 32'hC,   0, 32'hA000_0008, 32'h8, 32'hC, 0, 3));
      apply(v(1, 1, 32'hBAD0_0000, 0, 32'h0,   0,  1, 32'hC,   0, 32'hA000_0008, 32'h8, 32'hC, 0, 3));
      apply(v(1, 0, 32'h0,         0, 32'h0,   0,  1, 32'h100, 0, 32'hA000_0008, 32'h8, 32'hC, 0, 3));
      apply(v(1, 1, 32'hB000_0100, 0, 32'h0,   0,  1, 32'h100, 0, 32'hA000_0008, 32'h8, 32'hC, 0, 3));
      apply(v(1, 0, 32'h0,         0, 32'h0,   1,  0, 32'h100, 1, 32'hB000_0100, 32'h100, 32'h104, 0, 3));
      apply(v(1, 0, 32'h0,         0, 32'h0,   0,  1, 32'h104, 0, 32'hB000_0100, 32'h100, 32'h104, 0, 4));
      apply(v(1, 1, 32'hB000_0104, 0, 32'h0,   0,  1, 32'h104, 0, 32'hB000_0100, 32'h100, 32'h104, 0, 4));

      // Redirect and instr_ready together in VALID: not counted.
      apply(v(1, 0, 32'h0,         1, 32'h40,  1,  0, 32'h104, 1, 32'hB000_0104, 32'h104, 32'h108, 0, 4));
      // Redirect with ack in FETCH: data dropped, stay in FETCH at new target.
      apply(v(1, 1, 32'hBAD1_0000, 1, 32'h80,  0,  1, 32'h40,  0, 32'hB000_0104, 32'h104, 32'h108, 0, 4));
      // Two redirects while draining: the last one wins.
      apply(v(1, 0, 32'h0,         1, 32'h200, 0,  1, 32'h80,  0, 32'hB000_0104, 32'h104, 32'h108, 0, 4));
      apply(v(1, 0, 32'h0,         1, 32'h300, 0,  1, 32'h80,  0, 32'hB000_0104, 32'h104, 32'h108, 0, 4));
      apply(v(1, 1, 32'hBAD2_0000, 0, 32'h0,   0,  1, 32'h80,  0, 32'hB000_0104, 32'h104, 32'h108, 0, 4));

      // Wrap: fetch at 0xFFFF_FFFC, next fetch address is 0.
      apply(v(1, 1, 32'hBAD3_0000, 1, 32'hFFFF_FFFC, 0, 1, 32'h300, 0, 32'hB000_0104, 32'h104, 32'h108, 0, 4));
      apply(v(1, 1, 32'hCAFE_F00D, 0, 32'h0,   0,  1, 32'hFFFF_FFFC, 0, 32'hB000_0104, 32'h104, 32'h108, 0, 4));
      apply(v(1, 0, 32'h0,         0, 32'h0,   1,  0, 32'hFFFF_FFFC, 1, 32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h0, 0, 4));
      apply(v(1, 0, 32'h0,         0, 32'h0,   0,  1, 32'h0,   0, 32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h0, 0, 5));

      // Misaligned redirect with a request in flight: drain, then HALT.
      apply(v(1, 0, 32'h0,         1, 32'h102, 0,  1, 32'h0,   0, 32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h0, 0, 5));
      apply(v(1, 0, 32'h0,         0, 32'h0,   0,  1, 32'h0,   0, 32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h0, 1, 5));
      apply(v(1, 1, 32'hBAD4_0000, 0, 32'h0,   0,  1, 32'h0,   0, 32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h0, 1, 5));
      // HALT ignores every input for 20 cycles.
      for (int i = 0; i < 20; i++)
         apply(v(1, 1, 32'h1234_5678, 1, 32'h40, 1, 0, 32'h0, 0, 32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h0, 1, 5));

      // Reset clears the fault and restarts at RESET_PC.
      apply(v(0, 0, 32'h0,         0, 32'h0,   0,  0, 32'h0,   0, 32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h0, 1, 5));
      apply(v(0, 0, 32'h0,         0, 32'h0,   0,  0, 32'h0,   0, 32'h0,         32'h0,   32'h4,   0, 0));
      apply(v(1, 0, 32'h0,         0, 32'h0,   0,  1, 32'h0,   0, 32'h0,         32'h0,   32'h4,   0, 0));
      apply(v(1, 1, 32'hA000_0000, 0, 32'h0,   0,  1, 32'h0,   0, 32'h0,         32'h0,   32'h4,   0, 0));
      // Misaligned redirect in VALID halts at once.
      apply(v(1, 0, 32'h0,         1, 32'h3,   0,  0, 32'h0,   1, 32'hA000_0000, 32'h0,   32'h4,   0, 0));
      apply(v(1, 0, 32'h0,         0, 32'h0,   1,  0, 32'h0,   0, 32'hA000_0000, 32'h0,   32'h4,   1, 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset (word aligned).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  32  fetch byte address, bits[1:0]=0.
REQ-006 SHALL have port imem_ack  input  1  single-cycle pulse; imem_rdata valid that cycle.
REQ-007 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-008 SHALL have port redirect  input  1  taken branch/jump from datapath.
REQ-009 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-010 SHALL have port instr_valid  output  1  instr/pc hold a valid instruction.
REQ-011 SHALL have port instr_ready  input  1  datapath consumes instr this cycle.
REQ-012 SHALL have port instr  output  32  fetched instruction word.
REQ-013 SHALL have port pc  output  32  address of instr.
REQ-014 SHALL have port pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-015 SHALL have port fault  output  1  sticky misaligned-redirect error.
REQ-016 SHALL have port fetch_count  output  32  number of instructions consumed.

Function
REQ-017 SHALL implement states FETCH, VALID, DRAIN, HALT.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal fetch_pc; imem_addr SHALL stay stable until imem_ack.
REQ-019 In FETCH, on imem_ack without redirect: latch instr=imem_rdata, pc=fetch_pc, then go to VALID.
REQ-020 In VALID, instr_valid SHALL be 1 and imem_req SHALL be 0.
REQ-021 In VALID, on instr_ready without redirect: fetch_pc += 4, fetch_count += 1, then go to FETCH (one-bubble fetch; 3-cycle minimum per instruction with 1-cycle memory).
REQ-022 In VALID, redirect SHALL take priority over instr_ready: discard instr, do not increment fetch_count, set fetch_pc=redirect_pc, then go to FETCH.
REQ-023 In FETCH, on redirect with imem_ack in the same cycle: discard rdata, set fetch_pc=redirect_pc, then stay in FETCH.
REQ-024 In FETCH, on redirect without imem_ack: record the target, then go to DRAIN.
REQ-025 In DRAIN, imem_req and imem_addr SHALL be held for the old request until imem_ack; the response SHALL be discarded; then go to FETCH at the recorded target.
REQ-026 In DRAIN, a further redirect SHALL overwrite the recorded target (last wins).
REQ-027 On a redirect with redirect_pc[1:0]!=0 in any state: go to HALT and set fault=1.
REQ-028 A misaligned redirect in FETCH/DRAIN with a request outstanding SHALL still drain to imem_ack before HALT.
REQ-029 HALT SHALL hold imem_req=0, instr_valid=0 and fault=1 until reset, ignoring all inputs.
REQ-030 instr_valid SHALL be 0 in FETCH, DRAIN and HALT; instr/pc SHALL hold their last values.
REQ-031 fetch_pc and fetch_count SHALL wrap modulo 2^32 with no error.

Reset
REQ-032 When reset=0 at a clock edge: state=FETCH, fetch_pc=RESET_PC, instr=0, pc=0, fault=0, fetch_count=0.
REQ-033 While reset=0, imem_req SHALL be 0 and instr_valid SHALL be 0.
REQ-034 In the first cycle with reset=1, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-035 Reset asserted mid-request SHALL abandon the request; an imem_ack arriving during reset SHALL be ignored.

Structure
REQ-036 The state enum and the word-size and instruction-width constants SHALL live in the shared package mips_pkg.
REQ-037 The block SHALL be a single module with the FSM and PC datapath together; no sub-module.

Verification
REQ-038 Reset release, memory ack 1 cycle later -> imem_addr sequence 0x0,0x4,0x8; instr_valid every 3rd cycle with instr_ready=1; fetch_count=3 after three consumes.
REQ-039 instr_ready=0 for 5 cycles in VALID -> instr, pc stable; imem_req=0; fetch_count unchanged.
REQ-040 redirect to 0x100 in FETCH, ack 3 cycles later -> enter DRAIN, old data discarded, next imem_addr=0x100, first valid pc=0x100.
REQ-041 redirect to 0x40 and instr_ready in the same VALID cycle -> fetch_count not incremented; next imem_addr=0x40.
REQ-042 redirect_pc=0x102 -> fault=1, HALT, imem_req stays 0 for 20 cycles; reset clears fault and restarts at RESET_PC.
REQ-043 fetch_pc=0xFFFF_FFFC consumed -> next imem_addr=0x0; pc_plus4=0x0 while pc=0xFFFF_FFFC.
